// File: rtl/fib_table_arbiter_if.sv
// Lookup port bundle between the two requesters and the shared Fibonacci table.
// Each requester holds reqN high and idxN stable until it sees ackN. ackN is a
// one-cycle pulse, and valN/errN are valid from that cycle until the next ackN.
interface fib_table_arbiter_if #(
    parameter int IDX_W = 6,
    parameter int VAL_W = 23
);
    logic             req0;
    logic [IDX_W-1:0] idx0;
    logic             ack0;
    logic [VAL_W-1:0] val0;
    logic             err0;
    logic             req1;
    logic [IDX_W-1:0] idx1;
    logic             ack1;
    logic [VAL_W-1:0] val1;
    logic             err1;
    logic             busy;
    logic [1:0]       dbg_state;

    modport master (
        output req0, idx0, req1, idx1,
        input  ack0, val0, err0, ack1, val1, err1, busy, dbg_state
    );

    modport slave (
        input  req0, idx0, req1, idx1,
        output ack0, val0, err0, ack1, val1, err1, busy, dbg_state
    );
endinterface

// File: rtl/fib_table_arbiter.sv
// Round-robin arbitrated, registered-read Fibonacci table shared by two requesters.
// Each lookup passes through IDLE -> RD -> ACK. All outputs are registered.
module fib_table_arbiter #(
    parameter int IDX_W   = 6,
    parameter int VAL_W   = 23,
    parameter int MAX_IDX = 32
) (
    input logic               clk,
    input logic               rst,
    fib_table_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    function automatic logic [VAL_W-1:0] fib_const(input int n);
        logic [VAL_W-1:0] a;
        logic [VAL_W-1:0] b;
        logic [VAL_W-1:0] t;
        a = '0;
        b = VAL_W'(1);
        for (int i = 0; i < n; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    logic [VAL_W-1:0] fib_rom [MAX_IDX+1];

    for (genvar g = 0; g <= MAX_IDX; g++) begin : g_rom
        assign fib_rom[g] = fib_const(g);
    end

    state_t           state_q, state_d;
    logic             last_q, last_d;
    logic             gnt_q, gnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [VAL_W-1:0] res_q, res_d;
    logic             rerr_q, rerr_d;
    logic             busy_q, busy_d;
    logic             ack0_q, ack0_d;
    logic             ack1_q, ack1_d;
    logic [VAL_W-1:0] val0_q, val0_d;
    logic [VAL_W-1:0] val1_q, val1_d;
    logic             err0_q, err0_d;
    logic             err1_q, err1_d;

    // Full-width compare: out-of-range indices never alias onto table entries.
    logic [31:0] idx_ext;
    logic        idx_oor;
    assign idx_ext = 32'(idx_q);
    assign idx_oor = idx_ext > MAX_IDX;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
            gnt_q   <= 1'b0;
            idx_q   <= '0;
            res_q   <= '0;
            rerr_q  <= 1'b0;
            busy_q  <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            val0_q  <= '0;
            val1_q  <= '0;
            err0_q  <= 1'b0;
            err1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            res_q   <= res_d;
            rerr_q  <= rerr_d;
            busy_q  <= busy_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            val0_q  <= val0_d;
            val1_q  <= val1_d;
            err0_q  <= err0_d;
            err1_q  <= err1_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        res_d   = res_q;
        rerr_d  = rerr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    // On a tie the port that did not win last time goes first.
                    gnt_d   = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
                    last_d  = gnt_d;
                    idx_d   = gnt_d ? bus.idx1 : bus.idx0;
                    state_d = ST_RD;
                end
            end
            ST_RD: begin
                rerr_d  = idx_oor;
                res_d   = idx_oor ? '0 : fib_rom[idx_q];
                state_d = ST_ACK;
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        busy_d = (state_q != ST_IDLE);
        ack0_d = (state_q == ST_ACK) && !gnt_q;
        ack1_d = (state_q == ST_ACK) && gnt_q;
        val0_d = ack0_d ? res_q  : val0_q;
        err0_d = ack0_d ? rerr_q : err0_q;
        val1_d = ack1_d ? res_q  : val1_q;
        err1_d = ack1_d ? rerr_q : err1_q;
    end

    assign bus.ack0      = ack0_q;
    assign bus.ack1      = ack1_q;
    assign bus.val0      = val0_q;
    assign bus.val1      = val1_q;
    assign bus.err0      = err0_q;
    assign bus.err1      = err1_q;
    assign bus.busy      = busy_q;
    assign bus.dbg_state = state_q;
endmodule
